// File: rtl/pss_symbol_gen.sv
// NR PSS frequency-domain symbol generator: NFFT bins on an AXI-stream master, sequence from an LFSR.
// Define PSS_SYMBOL_GEN_TUSER_EN to add m_axis_out_tuser, which marks the 127 PSS-occupied bins.
module pss_symbol_gen #(
    parameter int OUT_DW    = 32,
    parameter int NFFT      = 256,
    parameter int AMPLITUDE = 8191
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        N_id_2_i,
    output logic              busy_o,
    output logic              err_o,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast
`ifdef PSS_SYMBOL_GEN_TUSER_EN
    ,
    output logic              m_axis_out_tuser
`endif
);

    localparam int HalfDw  = OUT_DW / 2;
    localparam int Kw      = $clog2(NFFT);
    localparam int PssLoI  = NFFT / 2 - 63;
    localparam int PssHiI  = NFFT / 2 + 63;
    localparam int LastKI  = NFFT - 1;
    localparam int Warm1I  = 42;
    localparam int Warm2I  = 85;
    localparam int AmpNegI = -AMPLITUDE;

    localparam logic [Kw-1:0]     PssLo     = PssLoI[Kw-1:0];
    localparam logic [Kw-1:0]     PssHi     = PssHiI[Kw-1:0];
    localparam logic [Kw-1:0]     LastK     = LastKI[Kw-1:0];
    localparam logic [Kw-1:0]     WarmLast1 = Warm1I[Kw-1:0];
    localparam logic [Kw-1:0]     WarmLast2 = Warm2I[Kw-1:0];
    localparam logic [HalfDw-1:0] AmpPos    = AMPLITUDE[HalfDw-1:0];
    localparam logic [HalfDw-1:0] AmpNeg    = AmpNegI[HalfDw-1:0];
    localparam logic [6:0]        LfsrSeed  = 7'b1110110;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StEmit
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [Kw-1:0] k_q, k_d;
    logic [1:0]  n_id_q, n_id_d;
    logic        err_q, err_d;

    logic [6:0]  lfsr_next;
    logic [Kw-1:0] warm_last;
    logic        emit;
    logic        pss_bin;
    logic        pss_on;
    logic [HalfDw-1:0] real_part;

    // s[6:0] = x(i+6)..x(i); shifting in x(i+7) = x(i+4) ^ x(i)
    assign lfsr_next = {lfsr_q[4] ^ lfsr_q[0], lfsr_q[6:1]};
    assign warm_last = (n_id_q == 2'd2) ? WarmLast2 : WarmLast1;
    assign emit      = (state_q == StEmit);
    assign pss_bin   = (k_q >= PssLo) && (k_q <= PssHi);
    assign pss_on    = emit && pss_bin;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        k_d     = k_q;
        n_id_d  = n_id_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (N_id_2_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        n_id_d  = N_id_2_i;
                        lfsr_d  = LfsrSeed;
                        k_d     = '0;
                        state_d = (N_id_2_i == 2'd0) ? StEmit : StWarmup;
                    end
                end
            end
            StWarmup: begin
                // k doubles as the warm-up cycle counter; 43*N_id_2 advances skip ahead
                lfsr_d = lfsr_next;
                if (k_q == warm_last) begin
                    k_d     = '0;
                    state_d = StEmit;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StEmit: begin
                if (m_axis_out_tready) begin
                    if (pss_bin) begin
                        lfsr_d = lfsr_next;
                    end
                    if (k_q == LastK) begin
                        k_d     = '0;
                        state_d = StIdle;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            lfsr_q  <= LfsrSeed;
            k_q     <= '0;
            n_id_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            k_q     <= k_d;
            n_id_q  <= n_id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        real_part = '0;
        if (pss_on) begin
            real_part = lfsr_q[0] ? AmpNeg : AmpPos;
        end
    end

    assign m_axis_out_tdata  = {{(OUT_DW - HalfDw){1'b0}}, real_part};
    assign m_axis_out_tvalid = emit;
    assign m_axis_out_tlast  = emit && (k_q == LastK);
    assign busy_o            = (state_q != StIdle);
    assign err_o             = err_q;

`ifdef PSS_SYMBOL_GEN_TUSER_EN
    assign m_axis_out_tuser = pss_on;
`endif

endmodule

// File: doc/pss_symbol_gen.md
Name: pss_symbol_gen

Overview:
- Transmit-side counterpart of the PSS detection chain: generates the NR PSS frequency-domain symbol for a selected N_id_2.
- Emits one NFFT-bin OFDM symbol on an AXI-stream master, ready for an IFFT.
- Used as a test-signal source and for loopback verification of the correlator/peak-detector path.
- Per bin n = 0..126: d(n) = 1 - 2·x((n + 43·N_id_2) mod 127), produced by an on-the-fly LFSR; no sequence ROM.

Parameters:
- OUT_DW, 32: output sample width; real part in [OUT_DW/2-1:0], imaginary part in [OUT_DW-1:OUT_DW/2].
- NFFT, 256: bins per symbol; power of two, at least 128.
- AMPLITUDE, 8191: magnitude of each PSS BPSK component; signed, must fit in OUT_DW/2 bits.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous, active-high reset.
- start_i, input, 1: request one symbol; sampled only in IDLE.
- N_id_2_i, input, 2: sector ID 0..2; captured with start_i.
- busy_o, output, 1: high whenever not in IDLE.
- err_o, output, 1: one-cycle pulse when start_i is seen in IDLE with N_id_2_i = 3.
- m_axis_out_tdata, output, OUT_DW: bin value.
- m_axis_out_tvalid, output, 1: bin valid.
- m_axis_out_tready, input, 1: downstream ready.
- m_axis_out_tlast, output, 1: high on bin NFFT-1.

Behaviour:
- Reset (asynchronous, any time, including mid-symbol): state = IDLE; all outputs 0; LFSR = 7'b1110110; bin counter = 0.
- LFSR state s[6:0] holds x(i+6)..x(i). Output bit is s[0]. Advance: s <= {s[4]^s[0], s[6:1]}.
- IDLE:
  - start_i with N_id_2_i in 0..2: latch N_id_2, reload LFSR seed, go to WARMUP; go directly to EMIT if N_id_2 = 0.
  - start_i with N_id_2_i = 3: stay in IDLE, pulse err_o for one cycle.
- WARMUP:
  - Advance the LFSR once per cycle for exactly 43·N_id_2 cycles (43 or 86), then go to EMIT.
  - tvalid stays 0.
- EMIT:
  - tvalid = 1 from the first cycle in EMIT; bin counter k runs 0..NFFT-1.
  - Bins NFFT/2-63 .. NFFT/2+63 carry PSS: real = +AMPLITUDE if s[0] = 0, -AMPLITUDE if s[0] = 1; imag = 0.
  - All other bins are 0.
  - k and the LFSR advance only on a handshake (tvalid & tready). The LFSR advances only on PSS bins.
  - tdata, tlast and tuser hold stable while tready = 0.
  - Handshake on k = NFFT-1 with tlast = 1: go to IDLE; tvalid falls on the next cycle.
- start_i outside IDLE is ignored; no queuing, no err_o.
- Symbol latency: first tvalid appears 1 + 43·N_id_2 cycles after the start_i edge. With tready held high, 43·N_id_2 + NFFT + 1 cycles after start_i the block is back in IDLE; back-to-back starts are allowed from then.
- Wrap: the LFSR period is 127, so no modulo logic is needed. The counter never exceeds NFFT-1.

Optional Feature:
- Macro PSS_SYMBOL_GEN_TUSER_EN.
- When defined: adds output port m_axis_out_tuser (1 bit), high exactly on the 127 PSS-occupied bins, with the same timing and stability as tdata.
- When undefined: the port does not exist and the logic is removed. tdata behaviour is identical in both builds.

Test Plan:
- N_id_2=0, NFFT=256, tready=1: first PSS bin at k=65; real parts of the first 8 PSS bins = +8191, -8191, -8191, +8191, -8191, -8191, -8191, -8191. Sum of all real parts = -8191. k=0..64 and k=192..255 are zero. tlast only at k=255. Exactly 256 beats.
- N_id_2=1 and N_id_2=2: tvalid first rises 44 and 87 cycles after start_i respectively. PSS bin sequences equal the N_id_2=0 sequence cyclically shifted by 43 and 86 positions.
- Random tready (about 50% duty): the captured symbol is bit-identical to the tready=1 capture; tdata is stable whenever tvalid=1 and tready=0; still exactly 256 beats.
- start_i with N_id_2_i=3: err_o high for 1 cycle; busy_o and tvalid stay 0. A second start_i while busy is ignored and the current symbol completes unchanged.
- reset_i asserted at k=100 for 1 cycle: tvalid and busy_o drop to 0 immediately (asynchronously). A following N_id_2=0 start reproduces the first scenario exactly.
- With PSS_SYMBOL_GEN_TUSER_EN defined: tuser is high on 127 beats, exactly k=65..191.
